pieo_pre_enq_tracker: RTL

Enqueue-side companion of the PIEO post-dequeue DRR scheduler. Watches per-queue FIFO occupancy and pushes one flow element per backlogged queue into the PIEO, round-robin, so each queue holds at most one PIEO entry or active service slot. Sits between the packet FIFOs, the PIEO enqueue port and the post-dequeue FSM:
- Consumes `post_deq_end` from the post-dequeue FSM to release a queue.
- Drives `fifos_not_enq_flag` so pending enqueues take priority over dequeues.

---
 rtl/pieo_pre_enq_tracker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pieo_pre_enq_tracker.sv
// pieo_pre_enq_tracker
// Enqueue-side companion of the PIEO post-dequeue DRR scheduler. Keeps at
// most one PIEO entry (or active service slot) per backlogged queue by
// tracking which queues already own one, and feeds untracked backlogged
// queues into the PIEO in round-robin order, one strobe every 2 cycles.
module pieo_pre_enq_tracker #(
    parameter int NUM_QUEUES = 3,
    parameter int ID_LOG     = $clog2(NUM_QUEUES),
    parameter int RANK_LOG   = 1,
    parameter int TIME_LOG   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en_in,
    input  logic [NUM_QUEUES-1:0]                fifo_tvalid,
    input  logic [NUM_QUEUES-1:0]                post_deq_end,
    input  logic                                 pieo_ready,
    input  logic                                 pieo_full,
    output logic                                 pieo_enq_trigger,
    output logic [ID_LOG+RANK_LOG+TIME_LOG-1:0]  pieo_enq_element,
    output logic                                 fifos_not_enq_flag,
    output logic [NUM_QUEUES-1:0]                tracked
);

    localparam int                    EW   = ID_LOG + RANK_LOG + TIME_LOG;
    localparam logic [ID_LOG:0]       NQ   = (ID_LOG+1)'(NUM_QUEUES);
    localparam logic [ID_LOG-1:0]     LAST = ID_LOG'(NUM_QUEUES - 1);
    localparam logic [NUM_QUEUES-1:0] ONE  = NUM_QUEUES'(1);

    typedef enum logic {
        IDLE,
        ENQ_GAP
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [ID_LOG-1:0]         rr_ptr;
    logic [ID_LOG-1:0]         rr_ptr_next;
    logic [EW-1:0]             elem_q;
    logic [EW-1:0]             elem_new;
    logic [NUM_QUEUES-1:0]     cand;
    logic [NUM_QUEUES-1:0]     set_mask;
    logic [2*NUM_QUEUES-1:0]   cand_dbl;
    logic [NUM_QUEUES-1:0]     cand_rot;
    logic [NUM_QUEUES-1:0]     rot_sh;
    logic [ID_LOG:0]           sel_sum;
    logic [ID_LOG-1:0]         sel;
    logic                      sel_valid;
    logic                      enq_fire;

    // Backlogged queues that do not yet own a PIEO entry or service slot.
    always_comb begin
        cand               = fifo_tvalid & ~tracked;
        fifos_not_enq_flag = |cand;
    end

    // Round-robin pick: rotate cand so rr_ptr lands at bit 0, find the lowest
    // set bit, then map the offset back to an absolute queue index mod N.
    // The loop runs from the highest offset down so the nearest one wins.
    always_comb begin
        cand_dbl  = {cand, cand} >> rr_ptr;
        cand_rot  = cand_dbl[NUM_QUEUES-1:0];
        rot_sh    = '0;
        sel_sum   = '0;
        sel_valid = 1'b0;
        for (int unsigned i = NUM_QUEUES; i > 0; i--) begin
            rot_sh = cand_rot >> (i - 1);
            if (rot_sh[0]) begin
                sel_sum   = {1'b0, rr_ptr} + (ID_LOG+1)'(i - 1);
                sel_valid = 1'b1;
            end
        end
        if (sel_sum >= NQ) begin
            sel = ID_LOG'(sel_sum - NQ);
        end else begin
            sel = sel_sum[ID_LOG-1:0];
        end
    end

    // Element layout {time, rank, id}; time and rank stay zero, so the
    // element can never be the all-ones invalid marker.
    always_comb begin
        elem_new             = '0;
        elem_new[ID_LOG-1:0] = sel;
    end

    // Next-state and strobe decode; ENQ_GAP enforces a dead cycle after
    // every strobe regardless of pieo_ready.
    always_comb begin
        state_next = state;
        enq_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && en_in && pieo_ready && !pieo_full && sel_valid) begin
                    enq_fire   = 1'b1;
                    state_next = ENQ_GAP;
                end
            end
            ENQ_GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobe outputs, pointer advance and tracking bit to set on a strobe.
    always_comb begin
        pieo_enq_trigger = enq_fire;
        pieo_enq_element = enq_fire ? elem_new : elem_q;
        rr_ptr_next      = (sel == LAST) ? '0 : sel + ID_LOG'(1);
        set_mask         = enq_fire ? (ONE << sel) : '0;
    end

    // State, tracking bitmap, round-robin pointer and held element.
    // Releases and a strobe on a different queue in the same cycle both apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tracked <= '0;
            rr_ptr  <= '0;
            elem_q  <= '0;
        end else begin
            state   <= state_next;
            tracked <= (tracked & ~post_deq_end) | set_mask;
            if (enq_fire) begin
                rr_ptr <= rr_ptr_next;
                elem_q <= elem_new;
            end
        end
    end

endmodule
